// File: rtl/interval_seq_pkg.sv
// Shared types and default sizing for the interval sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interval_seq_pkg;

  localparam int DEF_N     = 10;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/interval_table.sv
// DEPTH x N interval register file; one write port, one combinational read port.
// Latency: write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none, a write is accepted every cycle.
// Ports: clk, reset_n (async clear of all entries), wr_en/wr_addr/wr_data, rd_addr/rd_data.
module interval_table
  import interval_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/interval_sequencer.sv
// Walks a programmable interval table, driving a down-counter via load/enable/done and ticking per expiry.
// Latency: an entry of value V spans V+3 cycles from its LOAD cycle to the next LOAD/FINISH cycle.
// Backpressure: none; start is ignored while busy, stop always wins. Optional INTERVAL_SEQ_PAUSE_EN adds pause.
// Ports: clk, reset_n; table write wr_en/wr_addr/wr_data; cfg_last/cfg_loop latched on start;
//        start/stop control; timer_ld/timer_data/timer_en/timer_done to the timer;
//        tick, idx, busy, finished status (all outputs registered). pause only with INTERVAL_SEQ_PAUSE_EN.
module interval_sequencer
  import interval_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] cfg_last,
  input  logic          cfg_loop,
  input  logic          start,
  input  logic          stop,
`ifdef INTERVAL_SEQ_PAUSE_EN
  input  logic          pause,
`endif
  output logic          timer_ld,
  output logic [N-1:0]  timer_data,
  output logic          timer_en,
  input  logic          timer_done,
  output logic          tick,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          finished
);

  state_t        state;
  logic [AW-1:0] last_q;
  logic          loop_q;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  load_val;
  logic          run_en;

`ifdef INTERVAL_SEQ_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  // Read address is the entry the next LOAD will use: idx+1 while running a
  // non-last entry, otherwise 0 (fresh start or loop wrap).
  always_comb begin
    rd_addr = '0;
    if (state == RUN && idx != last_q) rd_addr = idx + AW'(1);
  end

  // Forward a same-cycle write so the LOAD sees the newest table value.
  assign load_val = (wr_en && wr_addr == rd_addr) ? wr_data : rd_data;

  interval_table #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_q     <= '0;
      loop_q     <= 1'b0;
      idx        <= '0;
      timer_ld   <= 1'b0;
      timer_data <= '0;
      timer_en   <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      tick     <= 1'b0;
      timer_ld <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        busy     <= 1'b0;
        finished <= 1'b0;
        timer_en <= 1'b0;
      end else begin
        case (state)
          IDLE, FINISH: begin
            if (start) begin
              last_q     <= cfg_last;
              loop_q     <= cfg_loop;
              idx        <= '0;
              busy       <= 1'b1;
              finished   <= 1'b0;
              state      <= LOAD;
              timer_ld   <= 1'b1;
              timer_data <= load_val;
              timer_en   <= 1'b0;
            end
          end
          LOAD: begin
            state    <= RUN;
            timer_en <= run_en;
          end
          RUN: begin
            if (timer_done) begin
              tick     <= 1'b1;
              timer_en <= 1'b0;
              if (idx != last_q || loop_q) begin
                idx        <= rd_addr;
                state      <= LOAD;
                timer_ld   <= 1'b1;
                timer_data <= load_val;
              end else begin
                state    <= FINISH;
                busy     <= 1'b0;
                finished <= 1'b1;
              end
            end else begin
              // Enable is registered, so a paused cycle suppresses counting one cycle later.
              timer_en <= run_en;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
